// File: rtl/cim_ctrl.sv
// CIM macro controller: strobes issue one cycle after acceptance; Q is captured LAT cycles later into a response FIFO.
// cmd_ready is credit-based, so the FIFO never overflows. Define CIM_CTRL_ACC_EN to accumulate COMPUTE results over last-flagged groups.
module cim_ctrl #(
  parameter int CORE_NUM         = 16,
  parameter int XIN_BIT_WIDTH    = 11,
  parameter int MEM_BIT_WIDTH    = 8,
  parameter int MEM_ADR_WIDTH    = 2,
  parameter int OUTPUT_BIT_WIDTH = 22,
  parameter int LAT              = 3,
  parameter int FIFO_DEPTH       = 4,
  parameter int ACC_W            = 26
) (
  input  logic                                CLK,
  input  logic                                NRST,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [1:0]                          cmd_op,
  input  logic [$clog2(CORE_NUM)-1:0]         cmd_bank,
  input  logic [MEM_ADR_WIDTH-1:0]            cmd_adr,
  input  logic [MEM_BIT_WIDTH-1:0]            cmd_data,
  input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   cmd_xin,
  input  logic                                cmd_last,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [1:0]                          rsp_op,
  output logic [ACC_W-1:0]                    rsp_data,
  output logic                                ENCB,
  output logic                                WEB,
  output logic                                REB,
  output logic [$clog2(CORE_NUM)-1:0]         BANKA,
  output logic [$clog2(CORE_NUM)-1:0]         BANKB,
  output logic [MEM_ADR_WIDTH-1:0]            ADRA,
  output logic [MEM_ADR_WIDTH-1:0]            ADRB,
  output logic [MEM_BIT_WIDTH-1:0]            D,
  output logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   XIN,
  input  logic [OUTPUT_BIT_WIDTH-1:0]         Q
);

  localparam int BANK_W = $clog2(CORE_NUM);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + LAT + 2);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

`ifdef CIM_CTRL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic                              cmd_fire;
  logic                              encb_q, web_q, reb_q;
  logic [BANK_W-1:0]                 banka_q, bankb_q;
  logic [MEM_ADR_WIDTH-1:0]          adra_q, adrb_q;
  logic [MEM_BIT_WIDTH-1:0]          d_q;
  logic [CORE_NUM*XIN_BIT_WIDTH-1:0] xin_q;

  logic                              iss_vld_q;
  logic [1:0]                        iss_op_q;
  logic                              iss_last_q;
  logic                              pipe_vld_q  [LAT];
  logic [1:0]                        pipe_op_q   [LAT];
  logic                              pipe_last_q [LAT];

  logic [CNT_W-1:0]                  inflight_cnt;
  logic [CNT_W-1:0]                  fifo_cnt_q;
  logic [PTR_W-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [1:0]                        fifo_op_q  [FIFO_DEPTH];
  logic [ACC_W-1:0]                  fifo_dat_q [FIFO_DEPTH];

  logic                              smp_vld, smp_last, push, pop;
  logic [1:0]                        smp_op;
  logic [ACC_W-1:0]                  q_sext, q_zext, cmp_dat, push_dat;

  // Only READs and group-closing COMPUTEs end up in the FIFO, so only they hold credit.
  function automatic logic wants_rsp(input logic vld, input logic [1:0] op, input logic last);
    return vld && ((op == OP_RD) || ((op == OP_CMP) && (last || !ACC_EN)));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight_cnt = CNT_W'(wants_rsp(iss_vld_q, iss_op_q, iss_last_q));
    for (int i = 0; i < LAT; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(wants_rsp(pipe_vld_q[i], pipe_op_q[i], pipe_last_q[i]));
    end
  end

  assign cmd_ready = NRST && ((fifo_cnt_q + inflight_cnt) < CNT_W'(FIFO_DEPTH));
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      encb_q     <= 1'b1;
      web_q      <= 1'b1;
      reb_q      <= 1'b1;
      banka_q    <= '0;
      bankb_q    <= '0;
      adra_q     <= '0;
      adrb_q     <= '0;
      d_q        <= '0;
      xin_q      <= '0;
      iss_vld_q  <= 1'b0;
      iss_op_q   <= OP_NOP;
      iss_last_q <= 1'b0;
    end else begin
      encb_q    <= 1'b1;
      web_q     <= 1'b1;
      reb_q     <= 1'b1;
      iss_vld_q <= cmd_fire && (cmd_op != OP_NOP);
      if (cmd_fire) begin
        iss_op_q   <= cmd_op;
        iss_last_q <= cmd_last;
        case (cmd_op)
          OP_WR: begin
            web_q   <= 1'b0;
            banka_q <= cmd_bank;
            adra_q  <= cmd_adr;
            d_q     <= cmd_data;
          end
          OP_RD: begin
            reb_q   <= 1'b0;
            bankb_q <= cmd_bank;
            adrb_q  <= cmd_adr;
          end
          OP_CMP: begin
            encb_q <= 1'b0;
            xin_q  <= cmd_xin;
          end
          default: ;
        endcase
      end
    end
  end

  // Stage i holds the command whose strobe fired i+1 cycles ago; the last stage lines up with Q.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_op_q[i]   <= OP_NOP;
        pipe_last_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= iss_vld_q;
      pipe_op_q[0]   <= iss_op_q;
      pipe_last_q[0] <= iss_last_q;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_op_q[i]   <= pipe_op_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  assign smp_vld  = pipe_vld_q[LAT-1];
  assign smp_op   = pipe_op_q[LAT-1];
  assign smp_last = pipe_last_q[LAT-1];
  assign q_sext   = {{(ACC_W-OUTPUT_BIT_WIDTH){Q[OUTPUT_BIT_WIDTH-1]}}, Q};
  assign q_zext   = {{(ACC_W-MEM_BIT_WIDTH){1'b0}}, Q[MEM_BIT_WIDTH-1:0]};
  assign push     = wants_rsp(smp_vld, smp_op, smp_last);
  assign push_dat = (smp_op == OP_RD) ? q_zext : cmp_dat;

`ifdef CIM_CTRL_ACC_EN
  logic [ACC_W-1:0] acc_q, acc_sum;

  assign acc_sum = acc_q + q_sext;
  assign cmp_dat = acc_sum;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      acc_q <= '0;
    end else if (smp_vld && (smp_op == OP_CMP)) begin
      acc_q <= smp_last ? '0 : acc_sum;
    end
  end
`else
  assign cmp_dat = q_sext;
`endif

  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_op    = rsp_valid ? fifo_op_q[rd_ptr_q]  : '0;
  assign rsp_data  = rsp_valid ? fifo_dat_q[rd_ptr_q] : '0;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_op_q[i]  <= '0;
        fifo_dat_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_op_q[wr_ptr_q]  <= smp_op;
        fifo_dat_q[wr_ptr_q] <= push_dat;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign ENCB  = encb_q;
  assign WEB   = web_q;
  assign REB   = reb_q;
  assign BANKA = banka_q;
  assign BANKB = bankb_q;
  assign ADRA  = adra_q;
  assign ADRB  = adrb_q;
  assign D     = d_q;
  assign XIN   = xin_q;

endmodule

// File: tb/tb_cim_ctrl.sv
// Bench for cim_ctrl: behavioural macro model drives Q from the strobes; a command-level scoreboard predicts responses.
module tb_cim_ctrl;
  localparam int CORE_NUM = 16, XW = 11, MW = 8, AW = 2, QW = 22, LAT = 3, FD = 4, ACC_W = 26;
  localparam int BW = 4;
  localparam int XT = CORE_NUM * XW;

  logic CLK = 1'b0, NRST = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [BW-1:0] cmd_bank = '0;
  logic [AW-1:0] cmd_adr = '0;
  logic [MW-1:0] cmd_data = '0;
  logic [XT-1:0] cmd_xin = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [1:0] rsp_op;
  logic [ACC_W-1:0] rsp_data;
  logic ENCB, WEB, REB;
  logic [BW-1:0] BANKA, BANKB;
  logic [AW-1:0] ADRA, ADRB;
  logic [MW-1:0] D;
  logic [XT-1:0] XIN;
  logic [QW-1:0] Q = '0;

  cim_ctrl dut (
    .CLK(CLK), .NRST(NRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_adr(cmd_adr), .cmd_data(cmd_data), .cmd_xin(cmd_xin), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .ENCB(ENCB), .WEB(WEB), .REB(REB), .BANKA(BANKA), .BANKB(BANKB), .ADRA(ADRA), .ADRB(ADRB),
    .D(D), .XIN(XIN), .Q(Q)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0, n_total = 0, mon_bad = 0, stab_bad = 0, send_to = 0;
  logic [27:0] exp_q[$], obs_q[$];
  logic [MW-1:0] ref_mem [CORE_NUM][4];
  logic [MW-1:0] mac_mem [CORE_NUM][4];
  logic [ACC_W-1:0] ref_acc = '0;
  logic [QW-1:0] dl [LAT+1];
  bit rnd_ready = 0;
  bit prev_hold = 0;
  logic [27:0] prev_rsp = '0;

  function automatic logic [QW-1:0] lane_sum(input logic [XT-1:0] x);
    int s;
    logic [XW-1:0] l;
    s = 0;
    for (int i = 0; i < CORE_NUM; i++) begin
      l = x[i*XW +: XW];
      s = s + int'($signed(l));
    end
    return QW'(s);
  endfunction

  // Macro model: acts on strobes mid-cycle, delivers Q so it is valid at the end of strobe cycle + LAT.
  always @(negedge CLK) begin
    logic [QW-1:0] v;
    v = QW'($urandom);
    if (!WEB) mac_mem[BANKA][ADRA] = D;
    if (!REB) v = {v[QW-1:MW], mac_mem[BANKB][ADRB]};
    if (!ENCB) v = lane_sum(XIN);
    if (int'(!ENCB) + int'(!WEB) + int'(!REB) > 1) mon_bad++;
    for (int k = LAT; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = v;
    Q = dl[LAT];
  end

  always @(negedge CLK) begin
    if (!NRST) begin
      prev_hold = 0;
    end else begin
      if (prev_hold && (!rsp_valid || {rsp_op, rsp_data} !== prev_rsp)) stab_bad++;
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_op, rsp_data};
      if (rsp_valid && rsp_ready) obs_q.push_back({rsp_op, rsp_data});
    end
  end

  task automatic model_accept(input logic [1:0] op, input logic [BW-1:0] b, input logic [AW-1:0] a,
                              input logic [MW-1:0] d, input logic [XT-1:0] x, input logic last);
    logic [QW-1:0] r;
    case (op)
      2'b01: ref_mem[b][a] = d;
      2'b10: exp_q.push_back({2'b10, {(ACC_W-MW){1'b0}}, ref_mem[b][a]});
      2'b11: begin
        r = lane_sum(x);
`ifdef CIM_CTRL_ACC_EN
        ref_acc = ref_acc + {{(ACC_W-QW){r[QW-1]}}, r};
        if (last) begin
          exp_q.push_back({2'b11, ref_acc});
          ref_acc = '0;
        end
`else
        exp_q.push_back({2'b11, {(ACC_W-QW){r[QW-1]}}, r});
`endif
      end
      default: ;
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [1:0] op, input logic [BW-1:0] b, input logic [AW-1:0] a,
                      input logic [MW-1:0] d, input logic [XT-1:0] x, input logic last);
    bit acc;
    acc = 0;
    cmd_valid = 1; cmd_op = op; cmd_bank = b; cmd_adr = a; cmd_data = d; cmd_xin = x; cmd_last = last;
    for (int c = 0; c < 200 && !acc; c++) begin
      if (rnd_ready) rsp_ready = 1'($urandom);
      @(negedge CLK);
      acc = cmd_ready;
      @(posedge CLK); #1;
    end
    cmd_valid = 0;
    if (acc) model_accept(op, b, a, d, x, last);
    else send_to++;
  endtask

  task automatic drain(output bit to);
    rsp_ready = 1; to = 1;
    for (int c = 0; c < 300; c++) begin
      cycles(1);
      if (obs_q.size() >= exp_q.size() && !rsp_valid) begin to = 0; break; end
    end
    cycles(LAT + 4);
  endtask

  task automatic test_reset;
    #1 NRST = 0;
    #2;
    n_total++; if ({ENCB, WEB, REB} !== 3'b111) $display("FAIL reset_strobes got %b want 111", {ENCB, WEB, REB}); else n_pass++;
    n_total++; if ({BANKA, BANKB, ADRA, ADRB, D} !== '0) $display("FAIL reset_addr got %h want 0", {BANKA, BANKB, ADRA, ADRB, D}); else n_pass++;
    n_total++; if (XIN !== '0) $display("FAIL reset_xin got %h want 0", XIN); else n_pass++;
    n_total++; if ({rsp_valid, rsp_op, rsp_data} !== '0) $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_op, rsp_data}); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cmd_ready); else n_pass++;
    repeat (3) @(posedge CLK);
    @(negedge CLK); NRST = 1; #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cmd_ready); else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_write;
    bit to; logic [27:0] o, e;
    send(2'b01, 4'd5, 2'd2, 8'hA5, '0, 1'b0);
    n_total++; if ({ENCB, WEB, REB} !== 3'b101) $display("FAIL wr_strobes got %b want 101", {ENCB, WEB, REB}); else n_pass++;
    n_total++; if ({BANKA, ADRA, D} !== {4'd5, 2'd2, 8'hA5}) $display("FAIL wr_fields got %h want %h", {BANKA, ADRA, D}, {4'd5, 2'd2, 8'hA5}); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got %b want 0", rsp_valid); else n_pass++;
    send(2'b00, 4'd7, 2'd3, 8'h11, '1, 1'b1);
    n_total++; if ({ENCB, WEB, REB} !== 3'b111) $display("FAIL nop_strobes got %b want 111", {ENCB, WEB, REB}); else n_pass++;
    send(2'b10, 4'd9, 2'd1, 8'h00, '0, 1'b0);
    n_total++; if ({ENCB, WEB, REB, BANKB} !== {3'b110, 4'd9}) $display("FAIL rd_strobes got %h want %h", {ENCB, WEB, REB, BANKB}, {3'b110, 4'd9}); else n_pass++;
    n_total++; if ({BANKA, ADRA, D} !== {4'd5, 2'd2, 8'hA5}) $display("FAIL idle_hold got %h want %h", {BANKA, ADRA, D}, {4'd5, 2'd2, 8'hA5}); else n_pass++;
    send(2'b10, 4'd5, 2'd2, 8'h00, '0, 1'b0);
    drain(to);
    n_total++; if (to || obs_q.size() != exp_q.size()) $display("FAIL wr_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL wr_rsp got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read;
    bit to; int k; logic [27:0] o, e;
    send(2'b01, 4'd3, 2'd1, 8'hC3, '0, 1'b0);
    rsp_ready = 0;
    send(2'b10, 4'd3, 2'd1, 8'h00, '0, 1'b0);
    for (k = 1; k <= 8; k++) begin
      if (rsp_valid) break;
      cycles(1);
    end
    n_total++; if (k != LAT + 2) $display("FAIL rd_latency got T+%0d want T+%0d", k, LAT + 2); else n_pass++;
    n_total++; if ({rsp_op, rsp_data} !== {2'b10, 26'h00000C3}) $display("FAIL rd_data got %h want %h", {rsp_op, rsp_data}, {2'b10, 26'h00000C3}); else n_pass++;
    cycles(2);
    n_total++; if ({rsp_valid, rsp_op, rsp_data} !== {1'b1, 2'b10, 26'h00000C3}) $display("FAIL rd_hold got %h want %h", {rsp_valid, rsp_op, rsp_data}, {1'b1, 2'b10, 26'h00000C3}); else n_pass++;
    drain(to);
    n_total++; if (to || obs_q.size() != exp_q.size()) $display("FAIL rd_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL rd_rsp got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_compute;
    bit to; logic [27:0] o, e, first;
    logic [XT-1:0] x;
    x = '0; x[XW-1:0] = 11'h7FE;
    send(2'b11, 4'd0, 2'd0, 8'h00, x, 1'b1);
    drain(to);
    first = (obs_q.size() > 0) ? obs_q[0] : '0;
    n_total++; if (first !== {2'b11, 26'h3FFFFFE}) $display("FAIL cmp_neg2 got %h want %h", first, {2'b11, 26'h3FFFFFE}); else n_pass++;
    x = '0; x[15*XW +: XW] = 11'd5; send(2'b11, 4'd0, 2'd0, 8'h00, x, 1'b0);
    x = '0; x[7*XW +: XW]  = 11'd7; send(2'b11, 4'd0, 2'd0, 8'h00, x, 1'b0);
    x = '0; x[XW-1:0] = 11'h7FE;   send(2'b11, 4'd0, 2'd0, 8'h00, x, 1'b1);
    drain(to);
`ifdef CIM_CTRL_ACC_EN
    first = (obs_q.size() > 1) ? obs_q[1] : '0;
    n_total++; if (first !== {2'b11, 26'd10}) $display("FAIL acc_sum got %h want %h", first, {2'b11, 26'd10}); else n_pass++;
`endif
    n_total++; if (to || obs_q.size() != exp_q.size()) $display("FAIL cmp_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL cmp_rsp got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_credit;
    bit to, fire; int idx, acc11; logic rdy11; logic [27:0] o, e;
    for (int i = 0; i < 5; i++) send(2'b01, BW'(i + 2), AW'(i), MW'(8'h30 + i * 17), '0, 1'b0);
    rsp_ready = 0; idx = 0; acc11 = -1; rdy11 = 1'b1;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      cmd_valid = 1; cmd_op = 2'b10; cmd_bank = BW'(idx + 2); cmd_adr = AW'(idx);
      rsp_ready = (cyc >= 12);
      @(negedge CLK);
      fire = cmd_ready;
      if (cyc == 11) begin acc11 = idx; rdy11 = cmd_ready; end
      @(posedge CLK); #1;
      if (fire) begin model_accept(2'b10, BW'(idx + 2), AW'(idx), '0, '0, 1'b0); idx++; end
    end
    cmd_valid = 0;
    n_total++; if (acc11 != FD) $display("FAIL credit_accepted got %0d want %0d", acc11, FD); else n_pass++;
    n_total++; if (rdy11 !== 1'b0) $display("FAIL credit_ready_full got %b want 0", rdy11); else n_pass++;
    n_total++; if (idx != 5) $display("FAIL credit_resume got %0d want 5", idx); else n_pass++;
    drain(to);
    n_total++; if (to || obs_q.size() != exp_q.size()) $display("FAIL credit_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL credit_rsp got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midop;
    rsp_ready = 0;
    send(2'b10, 4'd1, 2'd0, 8'h00, '0, 1'b0);
    cycles(LAT + 2);
    send(2'b10, 4'd2, 2'd1, 8'h00, '0, 1'b0);
    send(2'b10, 4'd3, 2'd2, 8'h00, '0, 1'b0);
    #1 NRST = 0; #1;
    n_total++; if ({ENCB, WEB, REB} !== 3'b111) $display("FAIL midrst_strobes got %b want 111", {ENCB, WEB, REB}); else n_pass++;
    n_total++; if ({rsp_valid, cmd_ready} !== 2'b00) $display("FAIL midrst_valid_ready got %b want 00", {rsp_valid, cmd_ready}); else n_pass++;
    exp_q.delete(); obs_q.delete(); ref_acc = '0;
    @(negedge CLK); @(negedge CLK);
    NRST = 1; #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL midrst_release_ready got %b want 1", cmd_ready); else n_pass++;
    @(posedge CLK); #1;
    rsp_ready = 1;
    cycles(LAT + 6);
    n_total++; if (obs_q.size() != 0 || rsp_valid !== 1'b0) $display("FAIL midrst_stale got %0d rsp want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_random;
    bit to; logic [27:0] o, e; logic [XT-1:0] x;
    rnd_ready = 1;
    for (int i = 0; i < 150; i++) begin
      x = XT'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      send(2'($urandom_range(0, 3)), BW'($urandom), AW'($urandom), MW'($urandom), x, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rnd_ready = 0;
    drain(to);
    n_total++; if (to || obs_q.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL rand_rsp got %h want %h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_total++; if (mon_bad != 0) $display("FAIL strobe_onehot got %0d bad cycles want 0", mon_bad); else n_pass++;
    n_total++; if (stab_bad != 0) $display("FAIL rsp_stable got %0d changes want 0", stab_bad); else n_pass++;
    n_total++; if (send_to != 0) $display("FAIL cmd_timeout got %0d want 0", send_to); else n_pass++;
  endtask

  initial begin
    for (int b = 0; b < CORE_NUM; b++)
      for (int a = 0; a < 4; a++) begin ref_mem[b][a] = '0; mac_mem[b][a] = '0; end
    for (int k = 0; k <= LAT; k++) dl[k] = '0;
    test_reset();
    test_write();
    test_read();
    test_compute();
    test_credit();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
